// File: rtl/reg_wb_file.sv
// -----------------------------------------------------------------------------
// reg_wb_file
//   Register file and writeback commit stage. Consumes the muxed writeback beat,
//   decodes write enable from the opcode, holds the write in a one-entry pending
//   register, and commits it to the array on the next unstalled edge. Two
//   combinational read ports are bypassed from the pending entry. A sticky halt
//   flag and a saturating commit counter are also kept.
//
// Ports
//   clk          in   1       rising-edge clock
//   reset        in   1       synchronous, active-high; clears all state
//   wb_valid_i   in   1       writeback beat present
//   wb_opcode_i  in   4       opcode of the beat
//   wb_dest_i    in   ADDR_W  destination register index
//   wb_data_i    in   8       writeback result
//   stall_i      in   1       freeze all state; beats presented are dropped
//   rd_addr_a_i  in   ADDR_W  read port A index
//   rd_addr_b_i  in   ADDR_W  read port B index
//   rd_data_a_o  out  8       read port A data (bypassed from pending entry)
//   rd_data_b_o  out  8       read port B data (bypassed from pending entry)
//   pend_vld_o   out  1       pending entry holds an uncommitted write
//   halted_o     out  1       sticky halt flag
//   commit_cnt_o out  CNT_W   saturating count of committed writes
// -----------------------------------------------------------------------------
module reg_wb_file #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid_i,
  input  logic [3:0]        wb_opcode_i,
  input  logic [ADDR_W-1:0] wb_dest_i,
  input  logic [7:0]        wb_data_i,
  input  logic              stall_i,
  input  logic [ADDR_W-1:0] rd_addr_a_i,
  input  logic [ADDR_W-1:0] rd_addr_b_i,
  output logic [7:0]        rd_data_a_o,
  output logic [7:0]        rd_data_b_o,
  output logic              pend_vld_o,
  output logic              halted_o,
  output logic [CNT_W-1:0]  commit_cnt_o
);

  typedef enum logic [3:0] {
    OpLb   = 4'b0000,
    OpLhb  = 4'b0001,
    OpJmp  = 4'b0010,
    OpStr  = 4'b0011,
    OpLim  = 4'b0100,
    OpMvb  = 4'b0101,
    OpMvf  = 4'b0110,
    OpAdd  = 4'b0111,
    OpSub  = 4'b1000,
    OpSft  = 4'b1001,
    OpBne  = 4'b1010,
    OpBeq  = 4'b1011,
    OpBlt  = 4'b1100,
    OpInc  = 4'b1101,
    OpHalt = 4'b1110,
    OpTba  = 4'b1111
  } opcode_e;

  // State
  logic [7:0]        regs_q [NUM_REGS];
  logic              pend_vld_q;
  logic [ADDR_W-1:0] pend_dest_q;
  logic [7:0]        pend_data_q;
  logic              halted_q;
  logic [CNT_W-1:0]  cnt_q;

  // Decode
  logic we;
  logic is_halt;
  logic capture;
  logic commit;
  logic halt_set;

  always_comb begin
    we      = 1'b0;
    is_halt = 1'b0;
    case (opcode_e'(wb_opcode_i))
      OpAdd, OpSub, OpSft, OpInc, OpLb, OpLhb, OpMvb, OpMvf, OpLim: we = 1'b1;
      OpHalt:                                                       is_halt = 1'b1;
      default:                                                      we = 1'b0;
    endcase
  end

  // Capture only ever samples wb_data_i when we=1, so a don't-care data bus on
  // non-writing beats never reaches the pending entry or the array.
  assign capture  = wb_valid_i & we & ~stall_i & ~halted_q;
  assign commit   = pend_vld_q & ~stall_i;
  assign halt_set = wb_valid_i & is_halt & ~stall_i;

  // Pending entry and halt flag
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_vld_q  <= 1'b0;
      pend_dest_q <= '0;
      pend_data_q <= 8'h00;
      halted_q    <= 1'b0;
    end else begin
      if (capture) begin
        pend_vld_q  <= 1'b1;
        pend_dest_q <= wb_dest_i;
        pend_data_q <= wb_data_i;
      end else if (commit) begin
        pend_vld_q  <= 1'b0;
      end
      if (halt_set) begin
        halted_q <= 1'b1;
      end
    end
  end

  // Register array; a write pending at reset is discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: 8'h00};
    end else if (commit) begin
      regs_q[pend_dest_q] <= pend_data_q;
    end
  end

  // Saturating commit counter
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (commit && !(&cnt_q)) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Read ports: bypass from pending entry only, never from the live beat.
  always_comb begin
    rd_data_a_o = regs_q[rd_addr_a_i];
    rd_data_b_o = regs_q[rd_addr_b_i];
    if (pend_vld_q && (pend_dest_q == rd_addr_a_i)) begin
      rd_data_a_o = pend_data_q;
    end
    if (pend_vld_q && (pend_dest_q == rd_addr_b_i)) begin
      rd_data_b_o = pend_data_q;
    end
  end

  assign pend_vld_o   = pend_vld_q;
  assign halted_o     = halted_q;
  assign commit_cnt_o = cnt_q;

endmodule

// File: tb/tb_reg_wb_file.sv
module tb_reg_wb_file;

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned CNT_W    = 4;  // small so saturation is reachable quickly

  logic              clk = 1'b0;
  logic              reset;
  logic              wb_valid;
  logic [3:0]        wb_opcode;
  logic [ADDR_W-1:0] wb_dest;
  logic [7:0]        wb_data;
  logic              stall;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [7:0]        rd_data_a;
  logic [7:0]        rd_data_b;
  logic              pend_vld;
  logic              halted;
  logic [CNT_W-1:0]  commit_cnt;

  int vectors = 0;
  int miscompares = 0;

  reg_wb_file #(
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wb_valid_i  (wb_valid),
    .wb_opcode_i (wb_opcode),
    .wb_dest_i   (wb_dest),
    .wb_data_i   (wb_data),
    .stall_i     (stall),
    .rd_addr_a_i (rd_addr_a),
    .rd_addr_b_i (rd_addr_b),
    .rd_data_a_o (rd_data_a),
    .rd_data_b_o (rd_data_b),
    .pend_vld_o  (pend_vld),
    .halted_o    (halted),
    .commit_cnt_o(commit_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rda(input string tag, input logic [ADDR_W-1:0] addr, input logic [7:0] exp);
    rd_addr_a = addr;
    #1;
    chk(tag, {8'h00, rd_data_a}, {8'h00, exp});
  endtask

  task automatic rdb(input string tag, input logic [ADDR_W-1:0] addr, input logic [7:0] exp);
    rd_addr_b = addr;
    #1;
    chk(tag, {8'h00, rd_data_b}, {8'h00, exp});
  endtask

  task automatic beat(input logic [3:0] op, input logic [ADDR_W-1:0] dest, input logic [7:0] data);
    wb_valid  = 1'b1;
    wb_opcode = op;
    wb_dest   = dest;
    wb_data   = data;
  endtask

  task automatic idle();
    wb_valid  = 1'b0;
    wb_opcode = 4'b0010;
    wb_dest   = '0;
    wb_data   = 8'h00;
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    rd_addr_a = '0;
    rd_addr_b = '0;
    idle();
    tick();
    tick();
    reset = 1'b0;

    // T1: preload r3, then reset clears it
    beat(4'b0100, 4'd3, 8'h5A);
    tick();
    idle();
    tick();
    rda("t1_preload_r3", 4'd3, 8'h5A);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rda("t1_reset_r3", 4'd3, 8'h00);
    chk("t1_reset_pend", {15'd0, pend_vld}, 16'd0);
    chk("t1_reset_halt", {15'd0, halted}, 16'd0);
    chk("t1_reset_cnt", {12'd0, commit_cnt}, 16'd0);

    // T2: latency and bypass
    beat(4'b0111, 4'd2, 8'h3C);
    rda("t2_no_live_bypass", 4'd2, 8'h00);
    tick();
    idle();
    chk("t2_pend_set", {15'd0, pend_vld}, 16'd1);
    rda("t2_bypass_r2", 4'd2, 8'h3C);
    chk("t2_cnt_before_commit", {12'd0, commit_cnt}, 16'd0);
    tick();
    chk("t2_pend_clear", {15'd0, pend_vld}, 16'd0);
    rda("t2_array_r2", 4'd2, 8'h3C);
    chk("t2_cnt", {12'd0, commit_cnt}, 16'd1);

    // T3: back-to-back writes to the same register
    beat(4'b0100, 4'd5, 8'h11);
    tick();
    rda("t3_first_bypass", 4'd5, 8'h11);
    beat(4'b0000, 4'd5, 8'h22);
    tick();
    idle();
    chk("t3_cnt_first_commit", {12'd0, commit_cnt}, 16'd2);
    rdb("t3_second_bypass", 4'd5, 8'h22);
    chk("t3_pend_held", {15'd0, pend_vld}, 16'd1);
    tick();
    rdb("t3_array_r5", 4'd5, 8'h22);
    rda("t3_both_ports_r5", 4'd5, 8'h22);
    chk("t3_cnt", {12'd0, commit_cnt}, 16'd3);

    // T4: non-writing opcodes, including an undriven data bus
    beat(4'b0011, 4'd1, 8'hFF);
    tick();
    beat(4'b1011, 4'd1, 8'hxx);
    tick();
    beat(4'b0010, 4'd1, 8'hFF);
    tick();
    beat(4'b0111, 4'd1, 8'hFF);
    wb_valid = 1'b0;
    tick();
    idle();
    chk("t4_pend", {15'd0, pend_vld}, 16'd0);
    rda("t4_r1", 4'd1, 8'h00);
    chk("t4_cnt", {12'd0, commit_cnt}, 16'd3);
    chk("t4_halt", {15'd0, halted}, 16'd0);

    // T5: stall freezes state and drops the presented beat
    beat(4'b0110, 4'd7, 8'h80);
    tick();
    stall = 1'b1;
    beat(4'b1101, 4'd8, 8'h55);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_stall_pend", {15'd0, pend_vld}, 16'd1);
      chk("t5_stall_cnt", {12'd0, commit_cnt}, 16'd3);
      rdb("t5_stall_r8", 4'd8, 8'h00);
    end
    stall = 1'b0;
    idle();
    tick();
    chk("t5_pend_clear", {15'd0, pend_vld}, 16'd0);
    rda("t5_r7", 4'd7, 8'h80);
    rdb("t5_r8_dropped", 4'd8, 8'h00);
    chk("t5_cnt", {12'd0, commit_cnt}, 16'd4);

    // T6: halt lets the pending write commit, then blocks captures
    beat(4'b1000, 4'd4, 8'h09);
    tick();
    beat(4'b1110, 4'd4, 8'hEE);
    tick();
    chk("t6_halted", {15'd0, halted}, 16'd1);
    chk("t6_halt_no_capture", {15'd0, pend_vld}, 16'd0);
    rda("t6_r4", 4'd4, 8'h09);
    chk("t6_cnt", {12'd0, commit_cnt}, 16'd5);
    beat(4'b0111, 4'd4, 8'h77);
    tick();
    idle();
    tick();
    chk("t6_add_blocked_pend", {15'd0, pend_vld}, 16'd0);
    rda("t6_r4_kept", 4'd4, 8'h09);
    chk("t6_cnt_kept", {12'd0, commit_cnt}, 16'd5);
    chk("t6_halt_sticky", {15'd0, halted}, 16'd1);

    // Reset with a write pending discards it
    reset = 1'b1;
    tick();
    reset = 1'b0;
    beat(4'b0100, 4'd6, 8'hAA);
    tick();
    idle();
    chk("t6_pend_before_reset", {15'd0, pend_vld}, 16'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_reset_pend", {15'd0, pend_vld}, 16'd0);
    rda("t6_reset_r6", 4'd6, 8'h00);
    rdb("t6_reset_r4", 4'd4, 8'h00);
    chk("t6_reset_cnt", {12'd0, commit_cnt}, 16'd0);
    chk("t6_reset_halt", {15'd0, halted}, 16'd0);

    // Counter saturation: 20 commits into a 4-bit counter
    for (int i = 0; i < 20; i++) begin
      beat(4'b0100, 4'(i), 8'(i + 1));
      tick();
    end
    idle();
    tick();
    chk("sat_cnt", {12'd0, commit_cnt}, 16'd15);
    rda("sat_r3_last", 4'd3, 8'd20);
    rdb("sat_r15", 4'd15, 8'd16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
